// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: scans the attribute table during h-blank for the next line,
// fetches up to MAX_VISIBLE sprite rows, then renders a prioritised palette index during active video.
module sprite_line_engine #(
    parameter int MAX_VISIBLE = 8,
    parameter int NUM_ATTRS   = 64,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int SPR_AW      = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [10:0]                  hcount,
    input  logic [9:0]                   vcount,
    output logic [$clog2(NUM_ATTRS)-1:0] attr_addr,
    input  logic [31:0]                  attr_data,
    output logic [SPR_AW-1:0]            spr_addr,
    input  logic [2*SPRITE_W-1:0]        spr_data,
    output logic                         pix_opaque,
    output logic [5:0]                   pix_index,
    output logic                         overflow,
    output logic                         collision
);
    localparam int AW = $clog2(NUM_ATTRS);
    localparam int VW = $clog2(MAX_VISIBLE + 1);
    localparam int SW = (MAX_VISIBLE > 1) ? $clog2(MAX_VISIBLE) : 1;
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int RB = 2 * SPRITE_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN_REQ = 3'd1,
        SCAN_CHK = 3'd2,
        FETCH    = 3'd3,
        LOAD     = 3'd4,
        DONE     = 3'd5
    } state_t;

    function automatic logic [1:0] pick_code(input logic [RB-1:0] row, input logic [CW-1:0] col);
        pick_code = row[{col, 1'b0} +: 2];
    endfunction

    state_t                 state_r;
    logic [AW-1:0]          ac_r;
    logic [VW-1:0]          vc_r;
    logic [MAX_VISIBLE-1:0] slot_valid_r;
    logic [9:0]             slot_x_r    [MAX_VISIBLE];
    logic [3:0]             slot_pal_r  [MAX_VISIBLE];
    logic                   slot_flip_r [MAX_VISIBLE];
    logic [RB-1:0]          slot_row_r  [MAX_VISIBLE];

    logic [9:0]        nl_s;
    logic [10:0]       nl_ext_s;
    logic [10:0]       y_ext_s;
    logic              hit_s;
    logic [RW-1:0]     row_s;
    logic [SPR_AW-1:0] fetch_addr_s;
    logic              last_s;
    logic              scanning_s;
    logic [SW-1:0]     slot_sel_s;

    // Hit test against the line being prepared and sprite-row address generation.
    always_comb begin
        nl_s         = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        nl_ext_s     = {1'b0, nl_s};
        y_ext_s      = {1'b0, attr_data[9:0]};
        hit_s        = (nl_ext_s >= y_ext_s) && (nl_ext_s < y_ext_s + 11'(SPRITE_H));
        row_s        = RW'(nl_ext_s - y_ext_s);
        fetch_addr_s = SPR_AW'(32'(attr_data[26:20]) * 32'(SPRITE_H) + 32'(row_s));
        last_s       = (ac_r == AW'(NUM_ATTRS - 1));
        scanning_s   = (state_r == SCAN_REQ) || (state_r == SCAN_CHK) ||
                       (state_r == FETCH)    || (state_r == LOAD);
        slot_sel_s   = vc_r[SW-1:0];
    end

    // Scan FSM; attr_addr is advanced together with ac so the synchronous table read lands in SCAN_CHK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            ac_r         <= '0;
            vc_r         <= '0;
            attr_addr    <= '0;
            spr_addr     <= '0;
            overflow     <= 1'b0;
            slot_valid_r <= '0;
            for (int k = 0; k < MAX_VISIBLE; k++) begin
                slot_x_r[k]    <= 10'd0;
                slot_pal_r[k]  <= 4'd0;
                slot_flip_r[k] <= 1'b0;
                slot_row_r[k]  <= '0;
            end
        end else if (scanning_s && hcount == 11'd1599) begin
            overflow <= 1'b1;
            state_r  <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hcount == 11'd1280) begin
                        state_r      <= SCAN_REQ;
                        slot_valid_r <= '0;
                        ac_r         <= '0;
                        vc_r         <= '0;
                        attr_addr    <= '0;
                        overflow     <= 1'b0;
                    end
                end
                SCAN_REQ: begin
                    attr_addr <= ac_r;
                    state_r   <= SCAN_CHK;
                end
                SCAN_CHK: begin
                    if (!hit_s) begin
                        if (last_s) begin
                            state_r <= DONE;
                        end else begin
                            ac_r      <= ac_r + AW'(1);
                            attr_addr <= ac_r + AW'(1);
                            state_r   <= SCAN_REQ;
                        end
                    end else if (vc_r == VW'(MAX_VISIBLE)) begin
                        overflow <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        slot_x_r[slot_sel_s]    <= attr_data[19:10];
                        slot_pal_r[slot_sel_s]  <= attr_data[31:28];
                        slot_flip_r[slot_sel_s] <= attr_data[27];
                        spr_addr                <= fetch_addr_s;
                        state_r                 <= FETCH;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    slot_row_r[slot_sel_s]   <= spr_data;
                    slot_valid_r[slot_sel_s] <= 1'b1;
                    vc_r                     <= vc_r + VW'(1);
                    if (last_s) begin
                        state_r <= DONE;
                    end else begin
                        ac_r      <= ac_r + AW'(1);
                        attr_addr <= ac_r + AW'(1);
                        state_r   <= SCAN_REQ;
                    end
                end
                DONE: begin
                    if (hcount == 11'd1599) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    logic [9:0]    px_s;
    logic          active_s;
    logic          cov_s;
    logic [CW-1:0] col_s;
    logic [1:0]    code_s;
    logic          any_s;
    logic          multi_s;
    logic [5:0]    idx_s;

    // Pixel priority: walk slots from highest to lowest so the lowest opaque slot is the final winner.
    always_comb begin
        px_s     = hcount[10:1];
        active_s = (hcount < 11'd1280) && (vcount < 10'd480);
        cov_s    = 1'b0;
        col_s    = '0;
        code_s   = 2'd0;
        any_s    = 1'b0;
        multi_s  = 1'b0;
        idx_s    = 6'd0;
        for (int k = MAX_VISIBLE - 1; k >= 0; k--) begin
            cov_s = slot_valid_r[k] && ({1'b0, px_s} >= {1'b0, slot_x_r[k]}) &&
                    ({1'b0, px_s} < {1'b0, slot_x_r[k]} + 11'(SPRITE_W));
            col_s = CW'(px_s - slot_x_r[k]);
            if (slot_flip_r[k]) begin
                col_s = CW'(SPRITE_W - 1) - col_s;
            end else begin
                col_s = col_s;
            end
            code_s = pick_code(slot_row_r[k], col_s);
            if (cov_s && code_s != 2'd0) begin
                multi_s = multi_s | any_s;
                any_s   = 1'b1;
                idx_s   = {slot_pal_r[k], code_s};
            end else begin
                multi_s = multi_s;
            end
        end
    end

    // Registered pixel output and frame-sticky collision flag (frame-start clear beats a same-cycle set).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_opaque <= 1'b0;
            pix_index  <= 6'd0;
            collision  <= 1'b0;
        end else begin
            if (active_s && any_s) begin
                pix_opaque <= 1'b1;
                pix_index  <= idx_s;
            end else begin
                pix_opaque <= 1'b0;
                pix_index  <= 6'd0;
            end
            if (hcount == 11'd0 && vcount == 10'd0) begin
                collision <= 1'b0;
            end else if (active_s && multi_s) begin
                collision <= 1'b1;
            end else begin
                collision <= collision;
            end
        end
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: behavioural attribute/sprite tables, jumps the raster
// counters to the lines and pixels of interest and checks hand-computed outputs.
module tb_sprite_line_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [5:0]  attr_addr;
    logic [31:0] attr_data;
    logic [11:0] spr_addr;
    logic [31:0] spr_data;
    logic        pix_opaque;
    logic [5:0]  pix_index;
    logic        overflow;
    logic        collision;

    int checks = 0;
    int errors = 0;

    logic [31:0] attr_mem [64];
    logic [31:0] spr_mem  [4096];

    sprite_line_engine dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .attr_addr(attr_addr), .attr_data(attr_data),
        .spr_addr(spr_addr), .spr_data(spr_data),
        .pix_opaque(pix_opaque), .pix_index(pix_index),
        .overflow(overflow), .collision(collision)
    );

    always #10 clk = ~clk;

    // Synchronous-read tables: data valid one cycle after the address.
    always @(posedge clk) begin
        attr_data <= attr_mem[attr_addr];
        spr_data  <= spr_mem[spr_addr];
    end

    function automatic logic [31:0] mk(input int y, input int x, input int pat, input int flip, input int pal);
        return {4'(pal), 1'(flip), 7'(pat), 10'(x), 10'(y)};
    endfunction

    task clear_attrs();
        for (int i = 0; i < 64; i++) attr_mem[i] = mk(1000, 0, 0, 0, 0);
    endtask

    task do_scan(input int v);
        vcount = 10'(v);
        for (int h = 1280; h < 1600; h++) begin
            hcount = 11'(h);
            @(posedge clk); #1;
        end
        hcount = 11'd100;
    endtask

    task probe(input int v, input int px, input int odd);
        vcount = 10'(v);
        hcount = 11'(2 * px + odd);
        @(posedge clk); #1;
    endtask

    task test_reset();
        checks++;
        if (pix_opaque !== 1'b0 || pix_index !== 6'd0 || overflow !== 1'b0 || collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags opaque=%b index=%h ovf=%b coll=%b expected all 0", pix_opaque, pix_index, overflow, collision);
        end
        checks++;
        if (attr_addr !== 6'd0 || spr_addr !== 12'd0) begin
            errors++;
            $display("FAIL reset_addr attr_addr=%0d spr_addr=%0d expected 0 0", attr_addr, spr_addr);
        end
    endtask

    task test_basic();
        int px  [5] = '{50, 65, 57, 49, 66};
        int odd [5] = '{0, 1, 1, 0, 1};
        logic op [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] ix [5] = '{6'h09, 6'h09, 6'h09, 6'h00, 6'h00};
        clear_attrs();
        attr_mem[0] = mk(100, 50, 3, 0, 2);
        spr_mem[48] = 32'h5555_5555;
        spr_mem[49] = 32'hAAAA_AAAA;
        do_scan(99);
        checks++;
        if (spr_addr !== 12'd48 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_scan spr_addr=%0d ovf=%b expected 48 0", spr_addr, overflow);
        end
        for (int i = 0; i < 5; i++) begin
            probe(100, px[i], odd[i]);
            checks++;
            if (pix_opaque !== op[i] || pix_index !== ix[i]) begin
                errors++;
                $display("FAIL basic_px%0d opaque=%b index=%h expected %b %h", px[i], pix_opaque, pix_index, op[i], ix[i]);
            end
        end
        do_scan(100);
        probe(101, 60, 0);
        checks++;
        if (pix_opaque !== 1'b1 || pix_index !== 6'h0A) begin
            errors++;
            $display("FAIL basic_row1 opaque=%b index=%h expected 1 0a", pix_opaque, pix_index);
        end
    endtask

    task test_hflip();
        int px [3] = '{215, 200, 214};
        logic [5:0] ix_f [3] = '{6'h1F, 6'h00, 6'h00};
        logic [5:0] ix_n [3] = '{6'h00, 6'h1F, 6'h00};
        clear_attrs();
        attr_mem[0] = mk(100, 200, 5, 1, 7);
        spr_mem[80] = 32'h0000_0003;
        do_scan(99);
        for (int i = 0; i < 3; i++) begin
            probe(100, px[i], 0);
            checks++;
            if (pix_opaque !== (ix_f[i] != 6'h00) || pix_index !== ix_f[i]) begin
                errors++;
                $display("FAIL hflip1_px%0d opaque=%b index=%h expected index %h", px[i], pix_opaque, pix_index, ix_f[i]);
            end
        end
        attr_mem[0] = mk(100, 200, 5, 0, 7);
        do_scan(99);
        for (int i = 0; i < 3; i++) begin
            probe(100, px[i], 0);
            checks++;
            if (pix_opaque !== (ix_n[i] != 6'h00) || pix_index !== ix_n[i]) begin
                errors++;
                $display("FAIL hflip0_px%0d opaque=%b index=%h expected index %h", px[i], pix_opaque, pix_index, ix_n[i]);
            end
        end
    endtask

    task test_collision();
        probe(0, 0, 0);
        clear_attrs();
        attr_mem[0] = mk(100, 300, 1, 0, 4);
        attr_mem[5] = mk(100, 300, 2, 0, 9);
        spr_mem[16] = 32'h5555_5555;
        spr_mem[32] = 32'hFFFF_FFFF;
        do_scan(99);
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_before coll=%b expected 0", collision);
        end
        probe(100, 300, 0);
        checks++;
        if (pix_opaque !== 1'b1 || pix_index !== 6'h11 || collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_overlap opaque=%b index=%h coll=%b expected 1 11 1", pix_opaque, pix_index, collision);
        end
        probe(150, 10, 0);
        checks++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_sticky coll=%b expected 1", collision);
        end
        probe(0, 0, 0);
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear coll=%b expected 0", collision);
        end
    endtask

    task test_overflow();
        clear_attrs();
        for (int k = 0; k < 9; k++) begin
            attr_mem[k] = mk(40, 20 * k + 4, k, 0, k + 1);
            spr_mem[16 * k] = 32'h5555_5555;
        end
        spr_mem[1] = 32'h5555_5555;
        do_scan(39);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set ovf=%b expected 1", overflow);
        end
        probe(40, 144, 0);
        checks++;
        if (pix_opaque !== 1'b1 || pix_index !== 6'h21) begin
            errors++;
            $display("FAIL ovf_slot7 opaque=%b index=%h expected 1 21", pix_opaque, pix_index);
        end
        probe(40, 164, 0);
        checks++;
        if (pix_opaque !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_ninth opaque=%b ovf=%b expected 0 1", pix_opaque, overflow);
        end
        for (int k = 1; k < 9; k++) attr_mem[k] = mk(1000, 0, 0, 0, 0);
        do_scan(40);
        probe(41, 4, 0);
        checks++;
        if (overflow !== 1'b0 || pix_opaque !== 1'b1 || pix_index !== 6'h05) begin
            errors++;
            $display("FAIL ovf_next ovf=%b opaque=%b index=%h expected 0 1 05", overflow, pix_opaque, pix_index);
        end
    endtask

    task test_boundary();
        clear_attrs();
        attr_mem[0] = mk(470, 10, 6, 0, 3);
        for (int r = 0; r < 16; r++) spr_mem[96 + r] = 32'h5555_5555;
        do_scan(469);
        probe(470, 10, 0);
        checks++;
        if (pix_opaque !== 1'b1 || pix_index !== 6'h0D) begin
            errors++;
            $display("FAIL bnd_470 opaque=%b index=%h expected 1 0d", pix_opaque, pix_index);
        end
        do_scan(478);
        probe(479, 10, 0);
        checks++;
        if (pix_opaque !== 1'b1 || pix_index !== 6'h0D) begin
            errors++;
            $display("FAIL bnd_479 opaque=%b index=%h expected 1 0d", pix_opaque, pix_index);
        end
        do_scan(479);
        probe(480, 10, 0);
        checks++;
        if (pix_opaque !== 1'b0 || pix_index !== 6'h00) begin
            errors++;
            $display("FAIL bnd_480 opaque=%b index=%h expected 0 00", pix_opaque, pix_index);
        end
        attr_mem[0] = mk(0, 100, 7, 0, 5);
        spr_mem[112] = 32'h5555_5555;
        do_scan(524);
        probe(0, 100, 0);
        checks++;
        if (pix_opaque !== 1'b1 || pix_index !== 6'h15) begin
            errors++;
            $display("FAIL bnd_line0 opaque=%b index=%h expected 1 15", pix_opaque, pix_index);
        end
    endtask

    task test_reset_mid();
        int px [4] = '{50, 65, 49, 66};
        logic [5:0] ix [4] = '{6'h09, 6'h09, 6'h00, 6'h00};
        clear_attrs();
        attr_mem[0] = mk(100, 50, 3, 0, 2);
        attr_mem[1] = mk(100, 50, 1, 0, 6);
        for (int k = 2; k < 9; k++) begin
            attr_mem[k] = mk(100, 400 + 20 * k, k, 0, 1);
            spr_mem[16 * k] = 32'h5555_5555;
        end
        spr_mem[48] = 32'h5555_5555;
        spr_mem[16] = 32'h5555_5555;
        do_scan(99);
        probe(100, 50, 0);
        checks++;
        if (collision !== 1'b1 || overflow !== 1'b1 || pix_index !== 6'h09) begin
            errors++;
            $display("FAIL rmid_setup coll=%b ovf=%b index=%h expected 1 1 09", collision, overflow, pix_index);
        end
        vcount = 10'd99;
        for (int h = 1280; h < 1300; h++) begin
            hcount = 11'(h);
            @(posedge clk); #1;
        end
        checks++;
        if (attr_addr !== 6'd4 || spr_addr !== 12'd64) begin
            errors++;
            $display("FAIL rmid_progress attr_addr=%0d spr_addr=%0d expected 4 64", attr_addr, spr_addr);
        end
        hcount = 11'd1300;
        reset  = 1'b1;
        #1;
        checks++;
        if (attr_addr !== 6'd0 || spr_addr !== 12'd0 || pix_opaque !== 1'b0 || pix_index !== 6'd0 ||
            overflow !== 1'b0 || collision !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset aa=%0d sa=%0d op=%b ix=%h ovf=%b coll=%b expected all 0",
                     attr_addr, spr_addr, pix_opaque, pix_index, overflow, collision);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        probe(100, 50, 0);
        checks++;
        if (pix_opaque !== 1'b0) begin
            errors++;
            $display("FAIL rmid_slots_cleared opaque=%b expected 0", pix_opaque);
        end
        clear_attrs();
        attr_mem[0] = mk(100, 50, 3, 0, 2);
        do_scan(99);
        for (int i = 0; i < 4; i++) begin
            probe(100, px[i], 0);
            checks++;
            if (pix_opaque !== (ix[i] != 6'h00) || pix_index !== ix[i] || collision !== 1'b0) begin
                errors++;
                $display("FAIL rmid_px%0d opaque=%b index=%h coll=%b expected index %h coll 0",
                         px[i], pix_opaque, pix_index, collision, ix[i]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        hcount = 11'd0;
        vcount = 10'd0;
        for (int i = 0; i < 4096; i++) spr_mem[i] = 32'h0;
        clear_attrs();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_basic();
        test_hflip();
        test_collision();
        test_overflow();
        test_boundary();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
